regfile: RTL and testbench
==========================

Name: regfile

Overview:
- General-purpose register file of the 5-stage MIPS pipeline: 32 x 32-bit registers.
- Serves the two combinational read ports driven by the decode stage.
- Accepts one write per cycle from the write-back stage.
- Provides write-through bypass, hardwired $zero, a registered debug read port and a retired-write counter for bench/trace use.

Parameters:
- DATA_W, 32, register width (`RegDataBus).
- ADDR_W, 5, register address width (`RegAddrBus).
- NREG, 32, number of registers (2**ADDR_W).
- CNT_W, 32, width of the write counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- we  in  1  write enable from write-back stage.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re1  in  1  read enable, port 1 (driven by decode).
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  DATA_W  read data, port 1 (combinational).
- re2  in  1  read enable, port 2.
- raddr2  in  ADDR_W  read address, port 2.
- rdata2  out  DATA_W  read data, port 2 (combinational).
- dbg_req  in  1  debug read request.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_valid  out  1  debug data valid, one-cycle pulse.
- dbg_data  out  DATA_W  debug read data (registered).
- wr_count  out  CNT_W  number of committed writes since reset.

Behaviour:
- Storage: NREG registers, updated on the rising clk edge.
- Write: if rst=0, we=1 and waddr!=0, then reg[waddr] <= wdata at the edge.
  - Writes to address 0 are dropped.
  - Reg 0 always reads 0.
- Reset (rst=1 at an edge, synchronous):
  - All registers cleared to 0.
  - dbg_valid<=0, dbg_data<=0, wr_count<=0.
  - A write presented in the same cycle as reset is discarded.
- Read ports 1 and 2 (combinational, identical rules; port 1 shown), priority order:
  1. rst=1 -> rdata1=0.
  2. re1=0 -> rdata1=0.
  3. raddr1=0 -> rdata1=0, even when a write to 0 is pending.
  4. we=1 and waddr==raddr1 -> rdata1=wdata (write-through bypass, same cycle).
  5. Otherwise rdata1=reg[raddr1].
- Both ports may read the same address; both receive the bypassed value if applicable.
- Both ports read independently; no port conflicts.
- Debug port (1-cycle latency):
  - When dbg_req=1 at an edge (rst=0): dbg_valid<=1 and dbg_data <= value of dbg_addr under the same rules as a read port with re=1, so the bypass applies.
  - When dbg_req=0 at an edge: dbg_valid<=0 and dbg_data holds its previous value.
  - Back-to-back requests give back-to-back valid pulses.
- wr_count:
  - Increments by 1 on each committed write (we=1, waddr!=0, rst=0).
  - Wraps modulo 2**CNT_W without saturation.
  - Writes to address 0 are not counted.
- No X propagation: all outputs are defined whenever rst is defined.

Test Plan:
- Reset/zero: assert rst for 2 cycles, then read all 32 addresses on both ports with re=1 -> every rdata=0; wr_count=0, dbg_valid=0.
- Write then read: write 0x1234ABCD to r5; next cycle raddr1=5, re1=1 -> rdata1=0x1234ABCD; same read with re1=0 -> rdata1=0; wr_count=1.
- Bypass: same cycle we=1, waddr=7, wdata=0xDEADBEEF, raddr1=raddr2=7, re1=re2=1 -> both rdata=0xDEADBEEF before the edge; after the edge the stored value is read.
- $zero: write 0xFFFFFFFF to r0 while raddr2=0, re2=1 -> rdata2=0 in that cycle and afterwards; wr_count unchanged.
- Debug port: r3=0x55; dbg_req=1, dbg_addr=3 -> next cycle dbg_valid=1, dbg_data=0x55; dbg_req dropped -> dbg_valid=0, dbg_data stays 0x55.
- Reset mid-operation: rst=1 in the same cycle as a write of 0xA to r9 -> r9 reads 0 afterwards, wr_count=0; 2**CNT_W writes with CNT_W=4 -> wr_count wraps to 0.

Source files
------------

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile: 32 x 32-bit general-purpose register file for the 5-stage MIPS
// pipeline. Two combinational read ports for decode, one write port from
// write-back, a hardwired $zero, same-cycle write-through bypass, a
// registered debug read port and a counter of committed writes.
//
// Ports:
//   clk, rst            pipeline clock, synchronous active-high reset
//   we, waddr, wdata    write port (write-back stage)
//   re1, raddr1, rdata1 read port 1 (combinational)
//   re2, raddr2, rdata2 read port 2 (combinational)
//   dbg_req, dbg_addr   debug read request
//   dbg_valid, dbg_data debug response, one cycle after the request
//   wr_count            committed writes since reset, wraps modulo 2**CNT_W
// ---------------------------------------------------------------------------
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_valid,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wr_count
);

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] dbg_rd;
    logic              commit;

    // A write to r0 is not a write at all: it neither lands nor counts.
    assign commit = we && (waddr != '0);

    // Shared read rule: reset and disabled ports return 0, r0 is always 0
    // (even with a pending write to it), then a same-cycle write wins over
    // the stored value.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rd_rst,
        input logic              rd_en,
        input logic [ADDR_W-1:0] rd_addr
    );
        logic [DATA_W-1:0] val;
        val = '0;
        if (rd_rst || !rd_en || rd_addr == '0)
            val = '0;
        else if (we && waddr == rd_addr)
            val = wdata;
        else
            val = regs[rd_addr];
        return val;
    endfunction

    always_comb begin
        rdata1 = read_port(rst, re1, raddr1);
        rdata2 = read_port(rst, re2, raddr2);
        dbg_rd = read_port(1'b0, 1'b1, dbg_addr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            dbg_valid <= 1'b0;
            dbg_data  <= '0;
            wr_count  <= '0;
        end else begin
            if (commit) begin
                regs[waddr] <= wdata;
                wr_count    <= wr_count + CNT_W'(1);
            end
            dbg_valid <= dbg_req;
            // Data is held between requests so trace tools can re-sample it.
            if (dbg_req)
                dbg_data <= dbg_rd;
        end
    end

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst, we, re1, re2, dbg_req;
    logic [4:0]  waddr, raddr1, raddr2, dbg_addr;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata2, dbg_data, wr_count;
    logic [31:0] rdata1_s, rdata2_s, dbg_data_s;
    logic        dbg_valid, dbg_valid_s;
    logic [3:0]  wr_count_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr),
        .dbg_valid(dbg_valid), .dbg_data(dbg_data), .wr_count(wr_count)
    );

    // Small-counter instance on the same stimulus to exercise the wrap.
    regfile #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1_s),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2_s),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr),
        .dbg_valid(dbg_valid_s), .dbg_data(dbg_data_s), .wr_count(wr_count_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    logic        m_dv;
    logic [31:0] m_dd;
    int unsigned m_cnt;
    bit          started = 0;

    function automatic logic [31:0] m_read(input logic r, input logic en, input logic [4:0] a);
        if (r || !en || a == 5'd0) return 32'h0;
        if (we && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                started = 1;
                foreach (m_regs[i]) m_regs[i] = 32'h0;
                m_dv = 0; m_dd = 0; m_cnt = 0;
            end else if (started) begin
                m_dv = dbg_req;
                if (dbg_req) m_dd = m_read(1'b0, 1'b1, dbg_addr);
                if (we && waddr != 5'd0) begin
                    m_regs[waddr] = wdata;
                    m_cnt++;
                end
            end
            @(negedge clk);
            if (started) begin
                check("m_rdata1", rdata1, m_read(rst, re1, raddr1));
                check("m_rdata2", rdata2, m_read(rst, re2, raddr2));
                check("m_dbg_valid", {31'b0, dbg_valid}, {31'b0, m_dv});
                check("m_dbg_data", dbg_data, m_dd);
                check("m_wr_count", wr_count, m_cnt);
                check("m_wr_count4", {28'b0, wr_count_s}, {28'b0, 4'(m_cnt)});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; we = 0; waddr = 0; wdata = 0; re1 = 0; raddr1 = 0;
        re2 = 0; raddr2 = 0; dbg_req = 0; dbg_addr = 0;
        tick(); tick();
        rst = 0;

        // reset / zero
        re1 = 1; re2 = 1;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a);
            #2;
            check("zero_rd1", rdata1, 32'h0);
            check("zero_rd2", rdata2, 32'h0);
            tick();
        end
        check("zero_cnt", wr_count, 32'h0);
        check("zero_dv", {31'b0, dbg_valid}, 32'h0);

        // write then read
        we = 1; waddr = 5; wdata = 32'h1234ABCD;
        tick();
        we = 0; re1 = 1; raddr1 = 5;
        #2 check("wr_rd1", rdata1, 32'h1234ABCD);
        re1 = 0;
        #1 check("wr_rd1_dis", rdata1, 32'h0);
        check("wr_cnt1", wr_count, 32'd1);
        tick();

        // bypass
        we = 1; waddr = 7; wdata = 32'hDEADBEEF;
        re1 = 1; re2 = 1; raddr1 = 7; raddr2 = 7;
        #2 check("byp_rd1", rdata1, 32'hDEADBEEF);
        check("byp_rd2", rdata2, 32'hDEADBEEF);
        tick();
        we = 0; wdata = 0;
        #2 check("byp_st1", rdata1, 32'hDEADBEEF);
        check("byp_st2", rdata2, 32'hDEADBEEF);
        tick();

        // $zero
        we = 1; waddr = 0; wdata = 32'hFFFFFFFF; raddr2 = 0;
        #2 check("zero_byp", rdata2, 32'h0);
        tick();
        we = 0;
        #2 check("zero_after", rdata2, 32'h0);
        check("zero_cnt2", wr_count, 32'd2);
        tick();

        // debug port
        we = 1; waddr = 3; wdata = 32'h55;
        tick();
        we = 0; dbg_req = 1; dbg_addr = 3;
        tick();
        #2 check("dbg_v1", {31'b0, dbg_valid}, 32'd1);
        check("dbg_d1", dbg_data, 32'h55);
        dbg_req = 0;
        tick();
        #2 check("dbg_v0", {31'b0, dbg_valid}, 32'd0);
        check("dbg_hold", dbg_data, 32'h55);
        // bypassed debug read, then back-to-back request
        we = 1; waddr = 4; wdata = 32'h77; dbg_req = 1; dbg_addr = 4;
        tick();
        we = 0; dbg_addr = 5;
        #2 check("dbg_byp", dbg_data, 32'h77);
        tick();
        #2 check("dbg_b2b_v", {31'b0, dbg_valid}, 32'd1);
        check("dbg_b2b_d", dbg_data, 32'h1234ABCD);
        dbg_req = 0;
        tick();

        // reset mid-operation with a concurrent write
        rst = 1; we = 1; waddr = 9; wdata = 32'hA;
        tick();
        rst = 0; we = 0; re1 = 1; raddr1 = 9; re2 = 1; raddr2 = 5;
        #2 check("rst_r9", rdata1, 32'h0);
        check("rst_r5", rdata2, 32'h0);
        check("rst_cnt", wr_count, 32'h0);
        check("rst_dd", dbg_data, 32'h0);
        tick();

        // counter wrap on the 4-bit instance after 16 committed writes
        for (int i = 0; i < 16; i++) begin
            we = 1; waddr = 5'((i % 31) + 1); wdata = 32'(i * 3 + 1);
            tick();
        end
        we = 0;
        #2 check("wrap_cnt4", {28'b0, wr_count_s}, 32'd0);
        check("wrap_cnt32", wr_count, 32'd16);
        tick();

        // mixed vectors, checked by the model every cycle
        for (int i = 0; i < 300; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            we       = $urandom_range(0, 1);
            waddr    = 5'($urandom_range(0, 31));
            wdata    = $urandom;
            re1      = ($urandom_range(0, 3) != 0);
            raddr1   = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
            re2      = ($urandom_range(0, 3) != 0);
            raddr2   = ($urandom_range(0, 2) == 0) ? raddr1 : 5'($urandom_range(0, 31));
            dbg_req  = $urandom_range(0, 1);
            dbg_addr = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
            tick();
        end
        rst = 0; we = 0; dbg_req = 0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
